vend_change_dispenser: RTL and testbench
========================================

// Module: vend_change_dispenser
// PURPOSE
//   Consumer of the vending FSM's change output. It accepts a change amount
//   (0..7 rupees) on a valid/ready request and breaks it greedily into
//   5/2/1 rupee coins. It drives one coin-hopper eject pulse per coin and
//   waits for the hopper's coin-exit acknowledge before ejecting the next.
//   It reports completion, the running rupees returned, and a timeout fault.
// PARAMETERS
//   CHANGE_W        3    width of req_amount / fault_amount (rupees)
//   PULSE_CYCLES    4    width of each hopper eject pulse, in clk cycles (>=1)
//   GAP_CYCLES      2    idle cycles between successive coins (>=1)
//   TIMEOUT_CYCLES  64   max cycles from pulse start to hop_done before fault
// PORTS
//   clk           in   1         system clock, rising edge
//   reset         in   1         asynchronous, active-low reset
//   req_valid     in   1         change request strobe (driven from vending FSM dispense)
//   req_amount    in   CHANGE_W  change to return, rupees; sampled on accept
//   req_ready     out  1         1 only in IDLE; accept = req_valid & req_ready
//   hop5_pulse    out  1         eject one 5-rupee coin (high PULSE_CYCLES)
//   hop2_pulse    out  1         eject one 2-rupee coin
//   hop1_pulse    out  1         eject one 1-rupee coin
//   hop_done      in   1         1-cycle coin-exit acknowledge from hopper
//   fault_clr     in   1         clears FAULT, returns to IDLE
//   busy          out  1         1 in every state except IDLE
//   coins_out     out  4         rupees delivered in current transaction
//   done          out  1         1-cycle pulse when the transaction completes
//   fault         out  1         1 in FAULT (hopper failed to acknowledge)
//   fault_amount  out  CHANGE_W  undelivered rupees held while in FAULT
// BEHAVIOUR
//   Reset (reset=0, async): state=IDLE, req_ready=1, all hop*_pulse=0,
//     busy=0, coins_out=0, done=0, fault=0, fault_amount=0, counters=0.
//     Reset asserted mid-operation drops pulses immediately. The partial
//     transaction is discarded.
//   States: IDLE, SELECT, PULSE, WAIT_ACK, GAP, DONE, FAULT.
//   IDLE: on accept at edge T, latch remaining=req_amount and clear coins_out.
//     If req_amount==0, go to DONE (done high in cycle T+1). Otherwise go to SELECT.
//   SELECT (1 cycle): denom = 5 if remaining>=5, else 2 if >=2, else 1.
//     Start the timeout counter and go to PULSE.
//   PULSE: exactly one hop*_pulse (for denom) is high for PULSE_CYCLES cycles.
//     The first pulse of a transaction is high from cycle T+2.
//     Never more than one hop*_pulse is high at a time.
//   WAIT_ACK: entered after the pulse. hop_done is counted from the first PULSE
//     cycle onward; an ack that arrives during PULSE is honoured at pulse end.
//   On ack: remaining -= denom and coins_out += denom, both registered.
//     If remaining==0, go to DONE. Otherwise go to GAP for GAP_CYCLES, then SELECT.
//   Timeout: if TIMEOUT_CYCLES elapse since pulse start with no ack, go to FAULT.
//     fault=1, fault_amount=remaining, req_ready=0.
//     FAULT is held until a fault_clr cycle, then IDLE (fault_amount -> 0).
//   DONE (1 cycle): done=1; coins_out holds the final total until next accept.
//   hop_done outside PULSE/WAIT_ACK is ignored.
//     A second hop_done for the same coin is ignored.
//   req_valid while busy is ignored (not queued); the producer must retry.
//   Greedy decomposition: 7=5+2, 6=5+1, 5=5, 4=2+2, 3=2+1, 2=2, 1=1.
//   coins_out never exceeds the latched req_amount.
//     It is 4 bits wide, so there is no overflow for CHANGE_W=3.
// TESTING
//   1. Hold reset=0 for 3 cycles -> req_ready=1, busy=0, all pulses/done/fault=0.
//   2. req_amount=3, hopper acks 2 cycles after each pulse start ->
//      hop2_pulse (4 cyc), gap, hop1_pulse (4 cyc), done 1 cycle, coins_out=3.
//   3. req_amount=7 -> one hop5_pulse then one hop2_pulse, hop1 never high,
//      coins_out=7.
//      Bench also checks the one-hot property of the pulses every cycle.
//   4. req_amount=0 -> done in cycle after accept, no hopper pulse, coins_out=0.
//   5. req_amount=5, hop_done never asserted -> fault=1 after 64 cycles,
//      fault_amount=5, req_ready=0.
//      Then fault_clr=1 for 1 cycle -> IDLE, fault=0.
//   6. req_amount=6, reset low during first hop5_pulse -> pulse drops immediately,
//      all outputs at reset values.
//      A new req_valid with req_amount=2 is then accepted normally.

Source files
------------

// File: rtl/vend_change_dispenser.sv
// Change dispenser: splits a 0..7 rupee change request greedily into 5/2/1 coins,
// pulses one hopper per coin, waits for the coin-exit ack, and faults on timeout.
module vend_change_dispenser #(
   parameter int CHANGE_W       = 3,
   parameter int PULSE_CYCLES   = 4,
   parameter int GAP_CYCLES     = 2,
   parameter int TIMEOUT_CYCLES = 64
) (
   input  logic                clk,
   input  logic                reset,
   input  logic                req_valid,
   input  logic [CHANGE_W-1:0] req_amount,
   output logic                req_ready,
   output logic                hop5_pulse,
   output logic                hop2_pulse,
   output logic                hop1_pulse,
   input  logic                hop_done,
   input  logic                fault_clr,
   output logic                busy,
   output logic [3:0]          coins_out,
   output logic                done,
   output logic                fault,
   output logic [CHANGE_W-1:0] fault_amount
);

   localparam logic [2:0] S_IDLE     = 3'd0;
   localparam logic [2:0] S_SELECT   = 3'd1;
   localparam logic [2:0] S_PULSE    = 3'd2;
   localparam logic [2:0] S_WAIT_ACK = 3'd3;
   localparam logic [2:0] S_GAP      = 3'd4;
   localparam logic [2:0] S_DONE     = 3'd5;
   localparam logic [2:0] S_FAULT    = 3'd6;

   localparam int PHASE_MAX = (PULSE_CYCLES > GAP_CYCLES) ? PULSE_CYCLES : GAP_CYCLES;
   localparam int CW        = $clog2(PHASE_MAX + 1);
   localparam int TW        = $clog2(TIMEOUT_CYCLES + 1);

   localparam logic [CW-1:0]       PULSE_LAST   = CW'(PULSE_CYCLES - 1);
   localparam logic [CW-1:0]       GAP_LAST     = CW'(GAP_CYCLES - 1);
   localparam logic [TW-1:0]       TIMEOUT_LAST = TW'(TIMEOUT_CYCLES - 1);
   localparam logic [CHANGE_W-1:0] AMT_FIVE     = CHANGE_W'(5);
   localparam logic [CHANGE_W-1:0] AMT_TWO      = CHANGE_W'(2);

   logic [2:0]          state;
   logic [CHANGE_W-1:0] remaining;
   logic [2:0]          denom;
   logic [CW-1:0]       phase_cnt;
   logic [TW-1:0]       timer;
   logic                ack_seen;
   logic                pulse_last;
   logic                take_ack;

   assign pulse_last = (phase_cnt == PULSE_LAST);

   // An ack caught during the pulse is held in ack_seen and consumed when the pulse ends.
   assign take_ack = ((state == S_PULSE) && pulse_last && (ack_seen || hop_done)) ||
                     ((state == S_WAIT_ACK) && hop_done);

   assign req_ready    = (state == S_IDLE);
   assign busy         = (state != S_IDLE);
   assign done         = (state == S_DONE);
   assign fault        = (state == S_FAULT);
   assign fault_amount = (state == S_FAULT) ? remaining : '0;
   assign hop5_pulse   = (state == S_PULSE) && (denom == 3'd5);
   assign hop2_pulse   = (state == S_PULSE) && (denom == 3'd2);
   assign hop1_pulse   = (state == S_PULSE) && (denom == 3'd1);

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state     <= S_IDLE;
         remaining <= '0;
         coins_out <= '0;
         denom     <= '0;
         phase_cnt <= '0;
         timer     <= '0;
         ack_seen  <= 1'b0;
      end else begin
         case (state)
            S_IDLE: begin
               if (req_valid) begin
                  remaining <= req_amount;
                  coins_out <= '0;
                  state     <= (req_amount == '0) ? S_DONE : S_SELECT;
               end
            end
            S_SELECT: begin
               if (remaining >= AMT_FIVE)
                  denom <= 3'd5;
               else if (remaining >= AMT_TWO)
                  denom <= 3'd2;
               else
                  denom <= 3'd1;
               timer     <= '0;
               phase_cnt <= '0;
               ack_seen  <= 1'b0;
               state     <= S_PULSE;
            end
            S_PULSE: begin
               timer <= timer + TW'(1);
               if (hop_done)
                  ack_seen <= 1'b1;
               if (pulse_last) begin
                  phase_cnt <= '0;
                  state     <= S_WAIT_ACK;
               end else begin
                  phase_cnt <= phase_cnt + CW'(1);
               end
            end
            S_WAIT_ACK: begin
               timer <= timer + TW'(1);
               if (!hop_done && (timer >= TIMEOUT_LAST))
                  state <= S_FAULT;
            end
            S_GAP: begin
               if (phase_cnt == GAP_LAST) begin
                  phase_cnt <= '0;
                  state     <= S_SELECT;
               end else begin
                  phase_cnt <= phase_cnt + CW'(1);
               end
            end
            S_DONE: begin
               state <= S_IDLE;
            end
            S_FAULT: begin
               if (fault_clr)
                  state <= S_IDLE;
            end
            default: begin
               state <= S_IDLE;
            end
         endcase

         // Coin delivered: overrides the per-state next-state chosen above.
         if (take_ack) begin
            remaining <= remaining - CHANGE_W'(denom);
            coins_out <= coins_out + {1'b0, denom};
            state     <= (remaining == CHANGE_W'(denom)) ? S_DONE : S_GAP;
         end
      end
   end

endmodule

// File: tb/tb_vend_change_dispenser.sv
// Bench for vend_change_dispenser: each request is expanded into an expected
// cycle-by-cycle output timeline from the greedy coin rules, then replayed and compared.
module tb_vend_change_dispenser;

   localparam int CHANGE_W       = 3;
   localparam int PULSE_CYCLES   = 4;
   localparam int GAP_CYCLES     = 2;
   localparam int TIMEOUT_CYCLES = 64;
   localparam int NEVER          = TIMEOUT_CYCLES + 3;
   localparam int FAULT_HOLD     = 3;
   localparam int MAXC           = 256;

   logic                clk;
   logic                reset;
   logic                req_valid;
   logic [CHANGE_W-1:0] req_amount;
   logic                req_ready;
   logic                hop5_pulse;
   logic                hop2_pulse;
   logic                hop1_pulse;
   logic                hop_done;
   logic                fault_clr;
   logic                busy;
   logic [3:0]          coins_out;
   logic                done;
   logic                fault;
   logic [CHANGE_W-1:0] fault_amount;

   int    errors;
   int    checks;
   int    last_coins;
   string test_name;

   logic [13:0] exp_vec [MAXC];
   logic        ack_drv [MAXC];
   logic        clr_drv [MAXC];

   vend_change_dispenser #(
      .CHANGE_W      (CHANGE_W),
      .PULSE_CYCLES  (PULSE_CYCLES),
      .GAP_CYCLES    (GAP_CYCLES),
      .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
   ) dut (
      .clk         (clk),
      .reset       (reset),
      .req_valid   (req_valid),
      .req_amount  (req_amount),
      .req_ready   (req_ready),
      .hop5_pulse  (hop5_pulse),
      .hop2_pulse  (hop2_pulse),
      .hop1_pulse  (hop1_pulse),
      .hop_done    (hop_done),
      .fault_clr   (fault_clr),
      .busy        (busy),
      .coins_out   (coins_out),
      .done        (done),
      .fault       (fault),
      .fault_amount(fault_amount)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Expected outputs packed as {hop5,hop2,hop1,done,busy,fault,ready,coins[3:0],fault_amount[2:0]}.
   function automatic logic [13:0] pack(input int den, input bit dn, input bit bs,
                                        input bit ft, input bit rd, input int cn, input int fa);
      logic [3:0] c4;
      logic [2:0] f3;
      c4 = 4'(cn);
      f3 = 3'(fa);
      return {den == 5, den == 2, den == 1, dn, bs, ft, rd, c4, f3};
   endfunction

   function automatic logic [13:0] observed();
      return {hop5_pulse, hop2_pulse, hop1_pulse, done, busy, fault, req_ready,
              coins_out, 3'(fault_amount)};
   endfunction

   task automatic check_output(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      if (obs !== exp) begin
         errors++;
         $display("[TB] FAIL %s: got %h expected %h", tag, obs, exp);
      end
   endtask

   task automatic fill(input int from, input int to, input logic [13:0] v);
      for (int k = from; k <= to; k++)
         exp_vec[k] = v;
   endtask

   function automatic int rand_delay();
      int r;
      r = $urandom_range(0, 19);
      if (r < 15)
         return $urandom_range(0, 8);
      else if (r < 18)
         return $urandom_range(9, TIMEOUT_CYCLES - 1);
      return NEVER;
   endfunction

   // Builds the expected timeline for one request and replays it cycle by cycle.
   // Cycle k=0 presents the request; delays are hopper ack offsets from each pulse start.
   task automatic apply_stimulus(input int amount, input int d0, input int d1);
      int dly[2];
      int rem, coins, cursor, p, e, denom, idx, len, f;
      logic [13:0] obs;
      dly[0] = d0;
      dly[1] = d1;
      for (int k = 0; k < MAXC; k++) begin
         exp_vec[k] = '0;
         ack_drv[k] = 1'b0;
         clr_drv[k] = 1'b0;
      end
      exp_vec[0] = pack(0, 0, 0, 0, 1, last_coins, 0);
      ack_drv[0] = ($urandom_range(0, 3) == 0);
      len = 0;
      if (amount == 0) begin
         exp_vec[1] = pack(0, 1, 1, 0, 0, 0, 0);
         exp_vec[2] = pack(0, 0, 0, 0, 1, 0, 0);
         len   = 3;
         coins = 0;
      end else begin
         rem    = amount;
         coins  = 0;
         cursor = 1;
         idx    = 0;
         exp_vec[1] = pack(0, 0, 1, 0, 0, 0, 0);
         while (rem > 0 && len == 0) begin
            denom = (rem >= 5) ? 5 : ((rem >= 2) ? 2 : 1);
            p = cursor + 1;
            if (dly[idx] >= TIMEOUT_CYCLES) begin
               fill(p, p + PULSE_CYCLES - 1, pack(denom, 0, 1, 0, 0, coins, 0));
               fill(p + PULSE_CYCLES, p + TIMEOUT_CYCLES - 1, pack(0, 0, 1, 0, 0, coins, 0));
               f = p + TIMEOUT_CYCLES + FAULT_HOLD;
               fill(p + TIMEOUT_CYCLES, f, pack(0, 0, 1, 1, 0, coins, rem));
               clr_drv[f] = 1'b1;
               exp_vec[f + 1] = pack(0, 0, 0, 0, 1, coins, 0);
               len = f + 2;
            end else begin
               ack_drv[p + dly[idx]] = 1'b1;
               if ($urandom_range(0, 1) == 1)
                  ack_drv[p + dly[idx] + 1] = 1'b1;
               e = p + ((dly[idx] >= PULSE_CYCLES) ? dly[idx] + 1 : PULSE_CYCLES);
               fill(p, p + PULSE_CYCLES - 1, pack(denom, 0, 1, 0, 0, coins, 0));
               fill(p + PULSE_CYCLES, e - 1, pack(0, 0, 1, 0, 0, coins, 0));
               coins = coins + denom;
               rem   = rem - denom;
               if (rem == 0) begin
                  exp_vec[e]     = pack(0, 1, 1, 0, 0, coins, 0);
                  exp_vec[e + 1] = pack(0, 0, 0, 0, 1, coins, 0);
                  len = e + 2;
               end else begin
                  fill(e, e + GAP_CYCLES, pack(0, 0, 1, 0, 0, coins, 0));
                  cursor = e + GAP_CYCLES;
               end
               idx++;
            end
         end
      end
      last_coins = coins;

      for (int k = 0; k < len; k++) begin
         obs = observed();
         check_output($sformatf("%s k%0d", test_name, k), 32'(obs), 32'(exp_vec[k]));
         check_output($sformatf("%s onehot k%0d", test_name, k),
                      32'($countones({hop5_pulse, hop2_pulse, hop1_pulse}) <= 1), 32'd1);
         if (k == 0) begin
            req_valid  = 1'b1;
            req_amount = CHANGE_W'(amount);
         end else begin
            req_valid  = (k < len - 1) && ($urandom_range(0, 3) == 0);
            req_amount = CHANGE_W'($urandom_range(0, 7));
         end
         hop_done  = ack_drv[k];
         fault_clr = clr_drv[k];
         @(posedge clk);
         #1;
      end
      req_valid = 1'b0;
      hop_done  = 1'b0;
      fault_clr = 1'b0;
   endtask

   initial begin
      errors     = 0;
      checks     = 0;
      last_coins = 0;
      reset      = 1'b0;
      req_valid  = 1'b0;
      req_amount = '0;
      hop_done   = 1'b0;
      fault_clr  = 1'b0;

      test_name = "reset";
      for (int i = 0; i < 3; i++) begin
         @(posedge clk);
         #1;
         check_output($sformatf("reset c%0d", i), 32'(observed()), 32'(pack(0, 0, 0, 0, 1, 0, 0)));
      end
      reset = 1'b1;

      test_name = "amt3";
      apply_stimulus(3, 2, 2);
      test_name = "amt7";
      apply_stimulus(7, 2, 2);
      test_name = "amt0";
      apply_stimulus(0, 0, 0);
      test_name = "amt5_timeout";
      apply_stimulus(5, NEVER, 0);

      // Reset in the middle of the first 5-rupee pulse.
      test_name  = "midreset";
      req_valid  = 1'b1;
      req_amount = CHANGE_W'(6);
      @(posedge clk);
      #1;
      req_valid = 1'b0;
      @(posedge clk);
      #1;
      check_output("midreset pulse", 32'(observed()), 32'(pack(5, 0, 1, 0, 0, 0, 0)));
      #2;
      reset = 1'b0;
      #1;
      check_output("midreset drop", 32'(observed()), 32'(pack(0, 0, 0, 0, 1, 0, 0)));
      @(posedge clk);
      @(posedge clk);
      #1;
      check_output("midreset hold", 32'(observed()), 32'(pack(0, 0, 0, 0, 1, 0, 0)));
      reset      = 1'b1;
      last_coins = 0;
      test_name  = "after_reset_amt2";
      apply_stimulus(2, 1, 0);

      for (int t = 0; t < 25; t++) begin
         int amt, a0, a1;
         amt = $urandom_range(0, 7);
         a0  = rand_delay();
         a1  = rand_delay();
         test_name = $sformatf("rand%0d_amt%0d", t, amt);
         apply_stimulus(amt, a0, a1);
      end

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
